// File: rtl/d_edge_pkg.sv
// Shared types and default parameters for the synchronizing edge debouncer.
package d_edge_pkg;
  typedef enum logic [1:0] {LOW, CHK_HIGH, HIGH, CHK_LOW} edge_state_t;

  localparam int unsigned SYNC_STAGES_DEF   = 2;
  localparam int unsigned STABLE_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF         = 8;
endpackage

// File: rtl/d_sync_chain.sv
// Plain shift of D flops used to bring an asynchronous bit into the clk domain.
module d_sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[SYNC_STAGES-2:0], d};
  end

  assign q = sr[SYNC_STAGES-1];
endmodule

// File: rtl/d_edge_debounce.sv
// Synchronize, debounce and edge-detect a raw input; counts accepted rising edges.
module d_edge_debounce
  import d_edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             cnt_ovf
);
  localparam int unsigned SW = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

  logic          s;
  edge_state_t   state, state_n;
  logic [SW-1:0] stab, stab_n;
  logic          rise_n, fall_n;

  d_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .d(d_in), .q(s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      stab  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      stab  <= stab_n;
      level <= (state_n == HIGH) || (state_n == CHK_LOW);
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  always_comb begin
    state_n = state;
    stab_n  = stab;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    unique case (state)
      LOW:      if (s) begin state_n = CHK_HIGH; stab_n = SW'(1); end
      CHK_HIGH: begin
        if (!s) begin
          state_n = LOW;
          stab_n  = '0;
        end else if (stab == STAB_MAX) begin
          state_n = HIGH;
          stab_n  = '0;
          rise_n  = 1'b1;
        end else begin
          stab_n  = stab + SW'(1);
        end
      end
      HIGH:     if (!s) begin state_n = CHK_LOW; stab_n = SW'(1); end
      CHK_LOW: begin
        if (s) begin
          state_n = HIGH;
          stab_n  = '0;
        end else if (stab == STAB_MAX) begin
          state_n = LOW;
          stab_n  = '0;
          fall_n  = 1'b1;
        end else begin
          stab_n  = stab + SW'(1);
        end
      end
      default: begin state_n = LOW; stab_n = '0; end
    endcase
  end

  // clr takes priority, but a rise accepted on the same edge still counts as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (clr) begin
      rise_cnt <= rise_n ? CNT_W'(1) : '0;
      cnt_ovf  <= 1'b0;
    end else if (rise_n) begin
      rise_cnt <= rise_cnt + CNT_W'(1);
      if (&rise_cnt) cnt_ovf <= 1'b1;
    end
  end
endmodule

// File: doc/d_edge_debounce.md
# d_edge_debounce

Synchronizing, glitch-filtering edge detector that sits directly downstream of the D flip-flop stage. It captures an asynchronous single-bit input through a flop synchronizer chain and accepts a new level only after it has been stable for a programmable number of cycles. It then emits one-cycle rise/fall pulses and counts accepted rising edges. It is the consumer that turns raw flop outputs (e.g. `Q`) into clean, countable events.

## Interface
- `SYNC_STAGES`, 2: number of synchronizer flops; must be ≥2.
- `STABLE_CYCLES`, 4: consecutive synchronized cycles a new level must hold before it is accepted; must be ≥2.
- `CNT_W`, 8: width of the rising-edge counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `d_in` in 1: asynchronous raw input, e.g. a flip-flop `Q`.
- `clr` in 1: synchronous clear of `rise_cnt` and `cnt_ovf` only.
- `level` out 1: debounced, accepted level.
- `rise` out 1: one-cycle pulse when `level` goes 0→1.
- `fall` out 1: one-cycle pulse when `level` goes 1→0.
- `rise_cnt` out CNT_W: number of accepted rising edges; wraps modulo 2^CNT_W.
- `cnt_ovf` out 1: sticky flag, set when `rise_cnt` wraps.

## Operation
- **Synchronizer:** `d_in` is shifted through `SYNC_STAGES` flops; the last stage is `s`. All stages reset to 0.
- **FSM states:** LOW, CHK_HIGH, HIGH, CHK_LOW. A stability counter `stab` has width ⌈log2(STABLE_CYCLES)⌉.
- **LOW:** `level`=0.
  - `s`=1 → CHK_HIGH, `stab`=1.
- **CHK_HIGH:** `level`=0.
  - `s`=0 → LOW, `stab`=0. The glitch is rejected and no pulse is emitted.
  - Else, if `stab`==STABLE_CYCLES-1 → HIGH. `rise`=1 for one cycle and `rise_cnt` increments.
  - Else `stab`++.
- **HIGH:** `level`=1.
  - `s`=0 → CHK_LOW, `stab`=1.
- **CHK_LOW:** `level`=1.
  - `s`=1 → HIGH, `stab`=0 (glitch rejected).
  - Else, if `stab`==STABLE_CYCLES-1 → LOW with `fall`=1 for one cycle.
  - Else `stab`++.
- **Outputs:** `level`, `rise` and `fall` are registered. `rise` and `fall` are never high together.
- **Counter wrap:** at `rise_cnt`=2^CNT_W-1, the next accepted rise sets it to 0 and sets `cnt_ovf`=1. `cnt_ovf` stays set until `clr` or `rst`.
- **`clr`:** sets `rise_cnt`=0 and `cnt_ovf`=0.
  - If `clr` and an accepted rise occur in the same cycle: `rise_cnt`=1, `cnt_ovf`=0.
  - `clr` has no effect on the FSM, synchronizer, `level` or the pulses.

## Timing
- **Reset values:** `level`=0, `rise`=0, `fall`=0, `rise_cnt`=0, `cnt_ovf`=0. State is LOW, `stab`=0, synchronizer is all 0.
- **Latency:** if `d_in` is stable before edge n, `level`, `rise`/`fall` and `rise_cnt` update at edge n+SYNC_STAGES+STABLE_CYCLES-1. With defaults, that is edge n+5.
- **Glitch rejection:** any excursion at `s` shorter than STABLE_CYCLES cycles produces no change on any output.
- **Minimum accepted period:** two accepted edges are at least STABLE_CYCLES cycles apart.
- **Reset mid-operation:** `rst` high at any edge forces all reset values on that edge, including aborting a pending CHK_* check.
  - A `d_in` that is held at 1 through reset is re-detected as a fresh rise with full latency, counted from the first edge with `rst` low.
- **Pulses:** each pulse lasts exactly one cycle, even if `clr` or `rst` is asserted in the following cycle.

## Structure
- **Package `d_edge_pkg`:**
  - state enum `edge_state_t` (LOW, CHK_HIGH, HIGH, CHK_LOW);
  - default constants `SYNC_STAGES_DEF`=2, `STABLE_CYCLES_DEF`=4, `CNT_W_DEF`=8.
- **Sub-module `d_sync_chain`:** parameterized by `SYNC_STAGES`, with ports `clk`, `rst`, `d`, `q`. It is a shift of D flops with synchronous reset to 0.
- **Top level:** the FSM, stability counter and event counter live in `d_edge_debounce`.

## Test plan
- **Reset and settle:** assert `rst` for 3 cycles with `d_in`=1, then release → `level` rises 5 cycles after the first cycle with `rst` low, with one `rise` pulse and `rise_cnt`=1.
- **Glitch rejection:** `d_in` 0→1 for 3 cycles, then back to 0 → `level`, `rise` and `rise_cnt` unchanged. Repeat with a 4-cycle pulse → accepted, `rise_cnt`+1, followed by a `fall` pulse.
- **Latency check:** step `d_in` 0→1 just before edge 20 → `rise` high only in the cycle after edge 25. Step 1→0 before edge 40 → `fall` high only after edge 45.
- **Counter wrap (CNT_W=2):** 4 accepted rises → `rise_cnt` sequence 1,2,3,0 with `cnt_ovf`=1 after the 4th. Pulse `clr` → `rise_cnt`=0, `cnt_ovf`=0.
- **Simultaneous `clr` and rise:** assert `clr` on the same edge as an accepted rise while `rise_cnt`=5 → `rise_cnt`=1, `cnt_ovf`=0.
- **Reset mid-check:** assert `rst` while in CHK_HIGH (2 stable cycles seen) → no `rise` pulse and all outputs 0 on the next cycle.
